// File: rtl/sensor_scan_mux.sv
// Registered sensor-channel selector with manual addressing and a round-robin auto scan with dwell gap.
// Optional feature: define CHANNEL_MASK_EN to add the ch_mask port and skip masked channels in auto scan.
module sensor_scan_mux #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] sensor_data,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [CH_W-1:0]          address,
  input  logic [DWELL_W-1:0]       dwell,
`ifdef CHANNEL_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        mux_out,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]         r_state;
  logic               r_valid;
  logic [DATA_W-1:0]  r_mux;
  logic [CH_W-1:0]    r_ch;
  logic               r_busy;
  logic [CH_W-1:0]    r_scan_ch;
  logic [DWELL_W-1:0] r_cnt;

  logic               w_hs;
  logic [CH_W-1:0]    w_scan_inc;
  logic [CH_W-1:0]    w_scan_nxt;
  logic [CH_W-1:0]    w_auto_ch;
  logic               w_auto_ok;
  logic [CH_W-1:0]    w_man_ch;
  logic [CH_W-1:0]    w_cap_ch;
  logic               w_cap_ok;
  logic [DATA_W-1:0]  w_cap_data;
  logic [1:0]         w_state_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               w_do_cap;

`ifdef CHANNEL_MASK_EN
  // First enabled channel at or after p, searching cyclically.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] p,
                                               input logic [NUM_CH-1:0] m);
    logic found;
    int   idx;
    next_ch = p;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(p) + i) % NUM_CH;
      if (!found && m[idx]) begin
        next_ch = CH_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction
`endif

  assign w_hs       = r_valid && out_ready;
  assign w_scan_inc = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
  // The pointer advances at the handshake, so a same-edge recapture sees the new value.
  assign w_scan_nxt = (r_state == HOLD && w_hs && mode) ? w_scan_inc : r_scan_ch;

`ifdef CHANNEL_MASK_EN
  assign w_auto_ch = next_ch(w_scan_nxt, ch_mask);
  assign w_auto_ok = |ch_mask;
`else
  assign w_auto_ch = w_scan_nxt;
  assign w_auto_ok = 1'b1;
`endif

  assign w_man_ch   = (32'(address) < NUM_CH) ? address : '0;
  assign w_cap_ch   = mode ? w_auto_ch : w_man_ch;
  assign w_cap_ok   = mode ? w_auto_ok : 1'b1;
  assign w_cap_data = sensor_data[32'(w_cap_ch)*DATA_W +: DATA_W];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_do_cap    = 1'b0;
    case (r_state)
      IDLE: begin
        w_do_cap = enable && w_cap_ok;
      end
      HOLD: begin
        if (w_hs) begin
          if (!enable) begin
            w_state_nxt = IDLE;
          end else if (mode && dwell == '0) begin
            w_do_cap    = w_cap_ok;
            w_state_nxt = IDLE;
          end else if (mode) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = dwell;
          end else begin
            w_do_cap = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_cnt == DWELL_W'(1)) begin
            w_do_cap    = w_cap_ok;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_do_cap) w_state_nxt = HOLD;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_mux     <= '0;
      r_ch      <= '0;
      r_busy    <= 1'b0;
      r_scan_ch <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= (w_state_nxt == HOLD);
      r_busy    <= (w_state_nxt != IDLE);
      r_scan_ch <= w_scan_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_do_cap) begin
        r_mux <= w_cap_data;
        r_ch  <= w_cap_ch;
      end
    end
  end

  assign out_valid = r_valid;
  assign mux_out   = r_mux;
  assign out_ch    = r_ch;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sensor_scan_mux.sv
// Directed-plus-random bench for sensor_scan_mux; expected samples come from a round-robin pointer model.
module tb_sensor_scan_mux;
  localparam int N  = 8;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic [N*DW-1:0] sensor_data;
  logic          enable;
  logic          mode;
  logic [2:0]    address;
  logic [7:0]    dwell;
`ifdef CHANNEL_MASK_EN
  logic [N-1:0]  ch_mask;
`endif
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] mux_out;
  logic [2:0]    out_ch;
  logic          busy;

  logic [DW-1:0] words [N];
  int total = 0;
  int bad   = 0;
  int exp_ch = 0;

  sensor_scan_mux dut (
    .clk(clk), .rst_n(rst_n), .sensor_data(sensor_data), .enable(enable),
    .mode(mode), .address(address), .dwell(dwell),
`ifdef CHANNEL_MASK_EN
    .ch_mask(ch_mask),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .mux_out(mux_out),
    .out_ch(out_ch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_words();
    for (int k = 0; k < N; k++) sensor_data[k*DW +: DW] = words[k];
  endtask

  task automatic rand_words();
    for (int k = 0; k < N; k++) words[k] = DW'($urandom);
    drive_words();
  endtask

  // One auto-mode sample: check the pending sample, stall, accept, then verify the dwell gap.
  task automatic auto_step(input int dw, input int stall);
    logic [DW-1:0] sd;
    logic [2:0]    sc;
    chk("auto_valid", out_valid, 1);
    chk("auto_ch", out_ch, exp_ch);
    chk("auto_data", mux_out, words[exp_ch]);
    sd = mux_out;
    sc = out_ch;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      rand_words();
      dwell = 8'($urandom);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_ch", out_ch, sc);
      chk("stall_data", mux_out, sd);
    end
    dwell = 8'(dw);
    rand_words();
    out_ready = 1'b1;
    tick();
    exp_ch = (int'(sc) + 1) % N;
    for (int i = 0; i < dw; i++) begin
      chk("gap_valid", out_valid, 0);
      out_ready = 1'($urandom);
      dwell = 8'($urandom);
      rand_words();
      tick();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; mode = 1'b0; address = 3'd0; dwell = 8'd0;
    out_ready = 1'b0;
`ifdef CHANNEL_MASK_EN
    ch_mask = '1;
`endif
    for (int k = 0; k < N; k++) words[k] = DW'(8'h10 + k);
    drive_words();
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_mux", mux_out, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_busy", busy, 0);

    // Manual streaming
    address = 3'd5; out_ready = 1'b1; rst_n = 1'b1;
    tick();
    chk("man_data", mux_out, 8'h15);
    chk("man_ch", out_ch, 5);
    chk("man_valid", out_valid, 1);
    chk("man_busy", busy, 1);
    address = 3'd2;
    tick();
    chk("man_data2", mux_out, 8'h12);
    chk("man_ch2", out_ch, 2);
    chk("man_valid2", out_valid, 1);
    enable = 1'b0;
    tick();
    chk("man_stop_valid", out_valid, 0);
    chk("man_stop_busy", busy, 0);

    // Auto scan back-to-back
    mode = 1'b1; dwell = 8'd0; enable = 1'b1; exp_ch = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_ch", out_ch, exp_ch);
      chk("b2b_data", mux_out, words[exp_ch]);
      if (i < 9) begin
        tick();
        exp_ch = (exp_ch + 1) % N;
      end
    end

    // Random dwell and backpressure against the pointer model
    for (int r = 0; r < 14; r++) auto_step(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    chk("rand_end_valid", out_valid, 1);
    chk("rand_end_ch", out_ch, exp_ch);
    chk("rand_end_data", mux_out, words[exp_ch]);

    // Reset overrides a pending sample
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ch", out_ch, 0);
    chk("mid_rst_mux", mux_out, 0);

    // Dwell 3 with a 4-cycle stall after the first valid
    rst_n = 1'b1; out_ready = 1'b0; dwell = 8'd3;
    rand_words();
    tick();
    exp_ch = 0;
    auto_step(3, 4);
    chk("dwell_valid", out_valid, 1);
    chk("dwell_ch", out_ch, 1);
    chk("dwell_data", mux_out, words[1]);

    // Enable drop in the second WAIT cycle
    dwell = 8'd3; out_ready = 1'b1;
    tick();
    chk("wait1_valid", out_valid, 0);
    chk("wait1_busy", busy, 1);
    tick();
    enable = 1'b0;
    tick();
    chk("drop_valid", out_valid, 0);
    chk("drop_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_idle_valid", out_valid, 0);
    end

`ifdef CHANNEL_MASK_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mode = 1'b1; dwell = 8'd0; out_ready = 1'b1;
    ch_mask = 8'b1010_0100; enable = 1'b1;
    tick();
    chk("mask_ch0", out_ch, 2);
    tick();
    chk("mask_ch1", out_ch, 5);
    tick();
    chk("mask_ch2", out_ch, 7);
    tick();
    chk("mask_ch3", out_ch, 2);
    enable = 1'b0;
    tick();
    ch_mask = '0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mask_zero_valid", out_valid, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
